// File: rtl/adc_pkg.sv
// Shared definitions for the serial ADC readout path: FSM state encoding,
// default geometry constants and a counter-width helper.
`timescale 1ns/1ps

package adc_pkg;

  localparam int ADC_DATA_W      = 16;
  localparam int ADC_CLK_DIV     = 2;
  localparam int ADC_CONV_CYCLES = 70;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    SHIFT,
    DONE
  } adc_rd_state_t;

  // Width of a counter that must be able to hold max_val.
  function automatic int cnt_w(input int max_val);
    return $clog2(max_val) + 1;
  endfunction

endpackage

// File: rtl/adc_sck_gen.sv
// Serial clock generator for the ADC readout. While run is high, sck toggles
// every CLK_DIV cycles; rise/fall flag the cycle whose closing edge moves sck
// 0->1 or 1->0. Dropping run clears the divider and parks sck low.
`timescale 1ns/1ps

module adc_sck_gen
  import adc_pkg::*;
#(
  parameter int CLK_DIV = ADC_CLK_DIV
) (
  input  logic clk_100,
  input  logic reset,
  input  logic run,
  output logic sck,
  output logic rise,
  output logic fall
);

  localparam int                DIV_W    = cnt_w(CLK_DIV);
  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_cnt;
  logic             tick;

  assign tick = run && (div_cnt == DIV_LAST);
  assign rise = tick && !sck;
  assign fall = tick && sck;

  // Divider and sck toggle; held cleared whenever the FSM is not shifting.
  always_ff @(posedge clk_100) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement or block ordering.
    if (reset || !run) begin
      div_cnt <= '0;
      sck     <= 1'b0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt <= '0;
      sck     <= ~sck;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/adc_spi_reader.sv
// Serial ADC readout master: holds cs high for the conversion time, clocks
// DATA_W bits in MSB-first on sck rising edges, then presents the sample on
// adc_data with a one-cycle en strobe. Runs back-to-back while start is high;
// dropping start mid-frame abandons the frame without an en pulse.
// Build option ADC_TWOS_COMP_EN: treat the ADC word as offset binary and
// invert the MSB when latching, giving two's-complement adc_data.
`timescale 1ns/1ps

module adc_spi_reader
  import adc_pkg::*;
#(
  parameter int DATA_W      = ADC_DATA_W,
  parameter int CLK_DIV     = ADC_CLK_DIV,
  parameter int CONV_CYCLES = ADC_CONV_CYCLES
) (
  input  logic              clk_100,
  input  logic              reset,
  input  logic              start,
  input  logic              mdi,
  output logic              sck,
  output logic              cs,
  output logic              en,
  output logic [DATA_W-1:0] adc_data,
  output logic              busy
);

  localparam int               CONV_W    = cnt_w(CONV_CYCLES);
  localparam int               BIT_W     = cnt_w(DATA_W);
  localparam logic [CONV_W-1:0] CONV_LAST = CONV_W'(CONV_CYCLES - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W);

  adc_rd_state_t     state;
  adc_rd_state_t     state_next;
  logic [CONV_W-1:0] conv_cnt;
  logic [BIT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] shreg;
  logic [DATA_W-1:0] sample;
  logic              run;
  logic              rise;
  logic              fall;
  logic              conv_last;
  logic              shift_last;

  assign run        = (state == SHIFT) && start;
  assign conv_last  = (conv_cnt == CONV_LAST);
  assign shift_last = fall && (bit_cnt == BIT_LAST);

`ifdef ADC_TWOS_COMP_EN
  localparam logic [DATA_W-1:0] MSB_MASK = {1'b1, {(DATA_W-1){1'b0}}};
  assign sample = shreg ^ MSB_MASK;
`else
  assign sample = shreg;
`endif

  adc_sck_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_sck_gen (
    .clk_100 (clk_100),
    .reset   (reset),
    .run     (run),
    .sck     (sck),
    .rise    (rise),
    .fall    (fall)
  );

  // Next-state decode; start low aborts any frame except one already in DONE.
  always_comb begin
    // NOTE: assigning the default before the case keeps every path driven,
    // so no latch is inferred for state_next.
    state_next = state;
    unique case (state)
      IDLE:    if (start) state_next = CONV;
      CONV:    if (!start) state_next = IDLE;
               else if (conv_last) state_next = SHIFT;
      SHIFT:   if (!start) state_next = IDLE;
               else if (shift_last) state_next = DONE;
      DONE:    state_next = start ? CONV : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk_100) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Registered cs/busy follow the state being entered; conversion timer.
  always_ff @(posedge clk_100) begin
    if (reset) begin
      cs       <= 1'b0;
      busy     <= 1'b0;
      conv_cnt <= '0;
    end else begin
      cs       <= (state_next == CONV);
      busy     <= (state_next != IDLE);
      conv_cnt <= (state == CONV && state_next == CONV) ? conv_cnt + CONV_W'(1) : '0;
    end
  end

  // Shift mdi in MSB-first on each sck rising edge and count bits.
  always_ff @(posedge clk_100) begin
    if (reset) begin
      bit_cnt <= '0;
      shreg   <= '0;
    end else if (state != SHIFT) begin
      bit_cnt <= '0;
    end else if (rise) begin
      shreg   <= {shreg[DATA_W-2:0], mdi};
      bit_cnt <= bit_cnt + BIT_W'(1);
    end
  end

  // Publish the completed sample with a single-cycle strobe.
  always_ff @(posedge clk_100) begin
    if (reset) begin
      en       <= 1'b0;
      adc_data <= '0;
    end else begin
      en <= (state == DONE);
      if (state == DONE) adc_data <= sample;
    end
  end

endmodule

// File: tb/tb_adc_spi_reader.sv
// Bench for adc_spi_reader: two instances (default geometry, and
// CLK_DIV=1/CONV_CYCLES=1), each looped back through a serial slave model.
// Expected samples go into a scoreboard queue when a frame is scheduled; a
// monitor pops and compares on every en pulse.
`timescale 1ns/1ps

module tb_adc_spi_reader;

  typedef struct {
    logic [15:0] data;
    int          gap;   // required cycles since previous en, 0 = don't care
  } exp_t;

  logic        clk_100 = 1'b0;
  logic        reset   = 1'b1;
  logic        start_a = 1'b0;
  logic        start_b = 1'b0;
  logic        mdi_a   = 1'b0;
  logic        mdi_b   = 1'b0;
  logic        sck_a, cs_a, en_a, busy_a;
  logic        sck_b, cs_b, en_b, busy_b;
  logic [15:0] data_a, data_b;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int last_en_a = 0;
  int last_en_b = 0;

  exp_t        exp_q_a[$];
  exp_t        exp_q_b[$];
  logic [15:0] slv_q_a[$];
  logic [15:0] slv_q_b[$];
  exp_t        mon_a, mon_b;
  logic [15:0] word_a = '0, word_b = '0;
  int          idx_a = 0, idx_b = 0;

  always #5 clk_100 = ~clk_100;
  always @(posedge clk_100) cyc <= cyc + 1;

  adc_spi_reader u_dut_a (
    .clk_100  (clk_100),
    .reset    (reset),
    .start    (start_a),
    .mdi      (mdi_a),
    .sck      (sck_a),
    .cs       (cs_a),
    .en       (en_a),
    .adc_data (data_a),
    .busy     (busy_a)
  );

  adc_spi_reader #(
    .DATA_W      (16),
    .CLK_DIV     (1),
    .CONV_CYCLES (1)
  ) u_dut_b (
    .clk_100  (clk_100),
    .reset    (reset),
    .start    (start_b),
    .mdi      (mdi_b),
    .sck      (sck_b),
    .cs       (cs_b),
    .en       (en_b),
    .adc_data (data_b),
    .busy     (busy_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [15:0] xf(input logic [15:0] v);
`ifdef ADC_TWOS_COMP_EN
    return v ^ 16'h8000;
`else
    return v;
`endif
  endfunction

  // Schedule one slave word; optionally expect it on adc_data.
  task automatic add_frame(input int i, input logic [15:0] v, input bit expect_it, input int gap);
    exp_t e;
    e.data = xf(v);
    e.gap  = gap;
    if (i == 0) begin
      slv_q_a.push_back(v);
      if (expect_it) exp_q_a.push_back(e);
    end else begin
      slv_q_b.push_back(v);
      if (expect_it) exp_q_b.push_back(e);
    end
  endtask

  // Slave model A: first bit on cs fall, next bit on each sck fall.
  always @(negedge cs_a) if (!reset) begin
    if (slv_q_a.size() > 0) word_a = slv_q_a.pop_front();
    else                    word_a = 16'h0000;
    idx_a = 15;
    mdi_a = word_a[15];
  end
  always @(negedge sck_a) if (!reset && idx_a > 0) begin
    idx_a--;
    mdi_a = word_a[idx_a];
  end

  // Slave model B.
  always @(negedge cs_b) if (!reset) begin
    if (slv_q_b.size() > 0) word_b = slv_q_b.pop_front();
    else                    word_b = 16'h0000;
    idx_b = 15;
    mdi_b = word_b[15];
  end
  always @(negedge sck_b) if (!reset && idx_b > 0) begin
    idx_b--;
    mdi_b = word_b[idx_b];
  end

  // Monitor A: compare every en against the scoreboard.
  always @(negedge clk_100) if (en_a === 1'b1) begin
    if (exp_q_a.size() == 0) check("a_spurious_en", exp_q_a.size(), 1);
    else begin
      mon_a = exp_q_a.pop_front();
      check("a_data", data_a, mon_a.data);
      if (mon_a.gap != 0) check("a_en_gap", cyc - last_en_a, mon_a.gap);
    end
    last_en_a = cyc;
  end

  // Monitor B.
  always @(negedge clk_100) if (en_b === 1'b1) begin
    if (exp_q_b.size() == 0) check("b_spurious_en", exp_q_b.size(), 1);
    else begin
      mon_b = exp_q_b.pop_front();
      check("b_data", data_b, mon_b.data);
      if (mon_b.gap != 0) check("b_en_gap", cyc - last_en_b, mon_b.gap);
    end
    last_en_b = cyc;
  end

  task automatic tick();
    @(negedge clk_100);
  endtask

  function automatic logic cs_of(input int i);
    return (i == 0) ? cs_a : cs_b;
  endfunction
  function automatic logic sck_of(input int i);
    return (i == 0) ? sck_a : sck_b;
  endfunction
  function automatic logic en_of(input int i);
    return (i == 0) ? en_a : en_b;
  endfunction

  task automatic wait_en(input int i, input int budget, input string tag);
    int n = 0;
    bit seen = 1'b0;
    while (!seen && n < budget) begin
      tick();
      n++;
      seen = (en_of(i) === 1'b1);
    end
    check({tag, "_en_seen"}, seen, 1);
  endtask

  // Entered on the first cs-high cycle; leaves on the en cycle.
  task automatic check_frame(input int i, input int conv, input int div, input string tag);
    int   high = 0, mism = 0, rises = 0;
    logic prev = 1'b0, s;
    while (cs_of(i) === 1'b1 && high < conv + 10) begin
      high++;
      tick();
    end
    check({tag, "_cs_high"}, high, conv);
    for (int k = 0; k <= 32 * div; k++) begin
      if (k > 0) tick();
      s = sck_of(i);
      if (s !== 1'((k / div) % 2)) mism++;
      if (en_of(i) !== 1'b0) mism++;
      if (s && !prev) rises++;
      prev = s;
    end
    check({tag, "_sck_pattern"}, mism, 0);
    check({tag, "_sck_rises"}, rises, 16);
    tick();
    check({tag, "_en_pulse"}, en_of(i), 1);
  endtask

  initial begin
    int   cnt;
    int   n;
    logic prev;

    start_a = 1'b1;
    add_frame(0, 16'hA5C3, 1'b1, 0);
    for (int v = 0; v < 10; v++) add_frame(0, 16'(v), 1'b1, 135);

    // Reset held with start high: everything quiet.
    repeat (5) begin
      tick();
      check("reset_outputs_a", {cs_a, sck_a, en_a, busy_a, data_a}, 0);
      check("reset_outputs_b", {cs_b, sck_b, en_b, busy_b, data_b}, 0);
    end
    reset = 1'b0;
    tick();
    check("cs_rise_after_reset", cs_a, 1);
    check("busy_after_reset", busy_a, 1);

    // First frame, then ten back-to-back frames returning 0..9.
    check_frame(0, 70, 2, "frame1");
    check("frame1_cs_rerise", cs_a, 1);
    for (int f = 0; f < 10; f++) begin
      wait_en(0, 200, "cont");
      check("cont_cs_rerise", cs_a, 1);
    end

    // Drop start on the DONE cycle of the next frame.
    add_frame(0, 16'h1234, 1'b1, 135);
    repeat (134) tick();
    start_a = 1'b0;
    tick();
    check("done_drop_en", en_a, 1);
    check("done_drop_cs", cs_a, 0);
    cnt = 0;
    repeat (200) begin
      tick();
      if (cs_a) cnt++;
    end
    check("done_drop_no_cs", cnt, 0);
    check("done_drop_busy", busy_a, 0);

    // Abort after the 8th sck rising edge.
    add_frame(0, 16'h5A5A, 1'b0, 0);
    start_a = 1'b1;
    tick();
    check("abort_cs_rise", cs_a, 1);
    cnt  = 0;
    n    = 0;
    prev = 1'b0;
    while (cnt < 8 && n < 400) begin
      tick();
      n++;
      if (sck_a && !prev) cnt++;
      prev = sck_a;
    end
    check("abort_rises", cnt, 8);
    start_a = 1'b0;
    tick();
    check("abort_cs", cs_a, 0);
    check("abort_sck", sck_a, 0);
    check("abort_busy", busy_a, 0);
    cnt = 0;
    repeat (300) begin
      tick();
      if (en_a) cnt++;
    end
    check("abort_no_en", cnt, 0);
    check("abort_data_hold", data_a, xf(16'h1234));

    // Restart after abort: a complete fresh frame.
    add_frame(0, 16'h0F0F, 1'b1, 0);
    start_a = 1'b1;
    tick();
    check("restart_cs", cs_a, 1);
    check_frame(0, 70, 2, "restart");
    start_a = 1'b0;
    repeat (5) tick();

    // Minimal geometry: CLK_DIV=1, CONV_CYCLES=1, 34-cycle frames.
    add_frame(1, 16'hFFFF, 1'b1, 0);
    add_frame(1, 16'hFFFF, 1'b1, 34);
    start_b = 1'b1;
    tick();
    check("sweep_cs_rise", cs_b, 1);
    check_frame(1, 1, 1, "sweep");
    wait_en(1, 60, "sweep2");
    start_b = 1'b0;
    repeat (5) tick();

    check("a_scoreboard_drained", exp_q_a.size(), 0);
    check("b_scoreboard_drained", exp_q_b.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/adc_spi_reader.md
Name: adc_spi_reader

Overview:
- Serial ADC readout master. Drives conversion strobe `cs` and serial clock `sck` to an external 16-bit ADC, or to the ADC imitator in simulation/bring-up.
- Shifts in `mdi` MSB-first and presents each completed sample as `adc_data` with a one-cycle `en` strobe.
- Sits between the ADC pins and the downstream sample-processing logic; runs continuously while `start` is high.

Parameters:
- `DATA_W`, 16, sample width in bits; `adc_data` width.
- `CLK_DIV`, 2, `sck` half-period in `clk_100` cycles (2 → 25 MHz); legal range ≥1.
- `CONV_CYCLES`, 70, `cs`-high conversion time in `clk_100` cycles (700 ns); legal range ≥1.

Ports:
- `clk_100`  in  1  system clock, 100 MHz.
- `reset`  in  1  synchronous reset, active-high.
- `start`  in  1  level enable; high = continuous acquisition, low = abort and idle.
- `mdi`  in  1  serial data from the ADC, valid around `sck` rising edge.
- `sck`  out  1  serial clock; idles low.
- `cs`  out  1  conversion strobe; high = convert, low = readout/idle.
- `en`  out  1  sample-valid pulse, exactly 1 cycle.
- `adc_data`  out  DATA_W  last completed sample.
- `busy`  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset values: `sck`=0, `cs`=0, `en`=0, `adc_data`=0, `busy`=0. FSM goes to IDLE; all counters are cleared.
- All outputs are registered. `reset` has priority over `start`.
- FSM states: IDLE, CONV, SHIFT, DONE.
- IDLE:
  - `cs`=0, `sck`=0.
  - `start`=1 → CONV on the next edge, with `cs`←1 and `conv_cnt`←0.
- CONV:
  - `cs`=1 for exactly CONV_CYCLES clocks.
  - At `conv_cnt`==CONV_CYCLES-1: `cs`←0, go to SHIFT, and clear `div_cnt` and `bit_cnt`.
- SHIFT:
  - `div_cnt` counts 0..CLK_DIV-1; at terminal count, `sck` toggles.
  - On the clock where `sck` goes 0→1: sample `mdi` into `shreg` (shift left, LSB in), and `bit_cnt`++.
  - After the DATA_W-th rising edge, wait for the matching falling edge (`sck` back to 0), then go to DONE.
  - Duration: DATA_W·2·CLK_DIV cycles (64 at defaults).
- DONE (one cycle):
  - `adc_data`←`shreg`, `en`←1.
  - `start`=1 → CONV (`cs`←1); `start`=0 → IDLE.
- Frame period at defaults: 70+64+1 = 135 cycles, i.e. 1.35 µs (740.7 kS/s).
- `en` is high only in the cycle after the DONE edge. `adc_data` holds until the next DONE.
- `start` falling in CONV or SHIFT: abort on the next edge.
  - `cs`←0, `sck`←0, go to IDLE.
  - No `en` pulse; `adc_data` retains its previous value; the partial `shreg` is discarded.
- `start` falling on the DONE cycle: the sample is still delivered (`en`=1), then IDLE.
- `start` re-asserted after an abort: a fresh full frame begins with CONV; no partial reuse.
- `busy`=1 in CONV/SHIFT/DONE, and deasserts the cycle after IDLE is entered.
- Counter widths: `$clog2` of the respective maximum +1. No wrap-around is reachable beyond the terminal counts.

Optional Feature:
- Macro: `ADC_TWOS_COMP_EN`.
- Defined: the ADC output is treated as offset binary, and the MSB is inverted when latching, so `adc_data` = `shreg` ^ (1<<(DATA_W-1)). Example: 16'h8000 → 16'h0000, 16'h0000 → 16'h8000.
- Undefined: `adc_data` = `shreg` unmodified.
- Timing is identical either way.

Decomposition:
- Shared package `adc_pkg`:
  - FSM state enum `adc_rd_state_t` {IDLE, CONV, SHIFT, DONE}.
  - Default constants `ADC_DATA_W`=16, `ADC_CLK_DIV`=2, `ADC_CONV_CYCLES`=70.
- One natural sub-module: `adc_sck_gen`, the divider/toggle that produces `sck` plus one-cycle `rise`/`fall` pulses, cleared by the FSM.
- Shift register and FSM stay in the top module.

Test Plan:
- Reset: hold `reset` for 5 cycles with `start`=1 → all outputs 0 and `busy`=0 throughout; first `cs` rise occurs 1 cycle after `reset` drops.
- Single frame: loop back with a serial slave model returning 16'hA5C3 → `cs` high for exactly 70 cycles; then 16 `sck` pulses, each 2 cycles high and 2 low; `en` for 1 cycle with `adc_data`=16'hA5C3 (or 16'h25C3 with `ADC_TWOS_COMP_EN`).
- Continuous: hold `start` high with slave values 0,1,2,…,9 → 10 `en` pulses exactly 135 cycles apart; `adc_data` matches the sequence; `cs` re-rises the cycle after each `en`.
- Abort: drop `start` after the 8th `sck` rising edge → `cs`=0 and `sck`=0 on the next edge; no `en`; `adc_data` keeps the prior value; `busy` falls.
- Edge case: drop `start` exactly on the DONE cycle → `en` still pulses with the correct data; no further `cs` rise.
- Parameter sweep: `CLK_DIV`=1, `CONV_CYCLES`=1, slave value 16'hFFFF → frame = 1+32+1 = 34 cycles; `adc_data`=16'hFFFF; `sck` high/low periods are 1 cycle each.
